uart_image_bridge: RTL and testbench

//  Byte-stream to memory bridge between the UART core and port b of the dual-port image memory.

---
 rtl/uart_image_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_uart_image_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_bridge.sv
// uart_image_bridge
//  Byte-stream to memory bridge between the UART core and port b of the
//  dual-port image memory.
//   'L' (0x4C): receive WIDTH*HEIGHT pixel bytes and write them to words
//               0..N-1, four pixels per word, little-endian. Reply 0x06.
//   'D' (0x44): read words RESULT_BASE..RESULT_BASE+N-1 and send each word
//               LSB first.
//  Optional feature (macro UART_IMAGE_BRIDGE_CHECKSUM_EN): an 8-bit XOR of all
//  image bytes, received or sent, is cleared on each command and sent as one
//  extra byte after the 0x06 (load) or after the last image byte (dump).
// Ports
//  clk, rst           system clock, asynchronous active-low reset
//  rx_data, rx_stb    received byte and its 1-cycle valid pulse
//  tx_data, tx_stb    byte to send; tx_stb held until tx_ack
//  tx_ack             1-cycle pulse: UART accepted tx_data
//  mem_en, mem_we     memory port enable / write enable
//  mem_addr, mem_dw   word address / write data
//  mem_dr             read data, valid 1 cycle after a read enable
//  busy               high in every state except IDLE
//  state_dbg          current FSM state encoding
// TX handshake: tx_data is stable while tx_stb=1. A cycle with tx_stb=1 and
// tx_ack=1 accepts the byte; tx_stb is low the following cycle, and a new byte
// is raised only from a cycle in which tx_stb is low, so one ack moves exactly
// one byte.
module uart_image_bridge #(
  parameter int WIDTH       = 352,
  parameter int HEIGHT      = 288,
  parameter int ADDR_WIDTH  = 16,
  parameter int RESULT_BASE = WIDTH * HEIGHT / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_stb,
  output logic [7:0]            tx_data,
  output logic                  tx_stb,
  input  logic                  tx_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_dw,
  input  logic [31:0]           mem_dr,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int N     = WIDTH * HEIGHT / 4;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] ACK_BYTE = 8'h06;

  if (WIDTH % 4 != 0) begin : g_bad_width
    $error("uart_image_bridge: WIDTH must be a multiple of 4");
  end
  if ((64'(RESULT_BASE) + 64'(N)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("uart_image_bridge: result image does not fit in ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_LOAD_ACK  = 3'd2,
    ST_DUMP_RD   = 3'd3,
    ST_DUMP_WAIT = 3'd4,
    ST_DUMP_TX   = 3'd5
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
    , ST_CSUM_TX = 3'd6
`endif
  } state_t;

`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
  localparam state_t ST_AFTER = ST_CSUM_TX;
`else
  localparam state_t ST_AFTER = ST_IDLE;
`endif

  state_t                state, next_state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_pulse;
  logic [31:0]           word_q;
  logic [1:0]            byte_sel;
  logic                  tx_want;
  logic [7:0]            tx_byte;
  logic                  tx_done;
  logic                  last_byte;
  logic                  last_word;
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign tx_done   = tx_stb & tx_ack;
  assign last_byte = (byte_cnt == CNT_W'(TOTAL - 1));
  assign last_word = (word_idx == ADDR_WIDTH'(N - 1));

  // Reads are a pure function of the state; writes are a registered pulse
  // in the cycle after the 4th byte of a word. The two never coincide.
  assign mem_en    = wr_pulse | (state == ST_DUMP_RD);
  assign mem_we    = wr_pulse;
  assign mem_addr  = (state == ST_DUMP_RD) ? (ADDR_WIDTH'(RESULT_BASE) + word_idx) : wr_addr;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_want    = 1'b0;
    tx_byte    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (rx_stb) begin
          if (rx_data == CMD_LOAD)      next_state = ST_LOAD;
          else if (rx_data == CMD_DUMP) next_state = ST_DUMP_RD;
        end
      end
      ST_LOAD: begin
        if (rx_stb && last_byte) next_state = ST_LOAD_ACK;
      end
      ST_LOAD_ACK: begin
        tx_want = 1'b1;
        tx_byte = ACK_BYTE;
        if (tx_done) next_state = ST_AFTER;
      end
      ST_DUMP_RD:   next_state = ST_DUMP_WAIT;
      ST_DUMP_WAIT: next_state = ST_DUMP_TX;
      ST_DUMP_TX: begin
        tx_want = 1'b1;
        tx_byte = word_q[{byte_sel, 3'b000} +: 8];
        if (tx_done && byte_sel == 2'd3) next_state = last_word ? ST_AFTER : ST_DUMP_RD;
      end
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
      ST_CSUM_TX: begin
        tx_want = 1'b1;
        tx_byte = csum;
        if (tx_done) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_stb   <= 1'b0;
      tx_data  <= 8'h00;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      mem_dw   <= 32'h0;
      word_q   <= 32'h0;
      byte_cnt <= '0;
      word_idx <= '0;
      byte_sel <= 2'd0;
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      wr_pulse <= 1'b0;
      // tx_stb is only raised from a low cycle, which yields the one-cycle gap.
      if (tx_stb) begin
        if (tx_ack) tx_stb <= 1'b0;
      end else if (tx_want) begin
        tx_stb  <= 1'b1;
        tx_data <= tx_byte;
      end
      case (state)
        ST_IDLE: begin
          if (rx_stb && (rx_data == CMD_LOAD || rx_data == CMD_DUMP)) begin
            byte_cnt <= '0;
            word_idx <= '0;
            byte_sel <= 2'd0;
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
            csum     <= 8'h00;
`endif
          end
        end
        ST_LOAD: begin
          if (rx_stb) begin
            mem_dw[{byte_cnt[1:0], 3'b000} +: 8] <= rx_data;
            if (byte_cnt[1:0] == 2'd3) begin
              wr_pulse <= 1'b1;
              wr_addr  <= ADDR_WIDTH'(byte_cnt >> 2);
            end
            if (!last_byte) byte_cnt <= byte_cnt + CNT_W'(1);
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end
        end
        ST_DUMP_WAIT: word_q <= mem_dr;
        ST_DUMP_TX: begin
          if (tx_done) begin
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3 && !last_word) word_idx <= word_idx + ADDR_WIDTH'(1);
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
            csum <= csum ^ tx_data;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_image_bridge.sv
// tb_uart_image_bridge
//  Directed bench for uart_image_bridge on a small 8x2 image (4 words) so that
//  full loads and dumps stay short. Models the memory port, drives tx_ack with
//  a programmable delay, and checks tx bytes and memory writes against
//  expected queues filled when stimulus is driven.
module tb_uart_image_bridge;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int AW = 8;
  localparam int NB = W * H;
  localparam int NW = NB / 4;
  localparam int RB = NW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_stb = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_stb;
  logic          tx_ack = 1'b0;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dw;
  logic [31:0]   mem_dr = 32'h0;
  logic          busy;
  logic [2:0]    state_dbg;

  logic [7:0]    exp_q[$];
  logic [39:0]   wexp_q[$];
  logic [31:0]   mem [256];
  logic [7:0]    img [NB];
  int            compared = 0;
  int            mismatched = 0;
  int            ack_delay = 0;
  int            ack_wait = 0;
  bit            ack_en = 1'b1;
  logic          prev_stb = 1'b0;
  logic [7:0]    prev_data = 8'h00;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = 32'h0;

  uart_image_bridge #(
    .WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW), .RESULT_BASE(RB)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dw(mem_dw), .mem_dr(mem_dr), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory model: 1-cycle read latency, plus a bench-side preload path
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] = pre_data;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_dw;
      else        mem_dr <= mem[mem_addr];
    end
  end

  // write scoreboard
  always @(negedge clk) begin
    if (rst && mem_en && mem_we) begin
      check("wr_has_exp", 64'(wexp_q.size() != 0), 64'd1);
      if (wexp_q.size() != 0) check("wr_addr_data", 64'({mem_addr, mem_dw}), 64'(wexp_q.pop_front()));
    end
  end

  // tx monitor and ack driver; the byte is scored when the ack is raised
  always @(negedge clk) begin
    if (rst) begin
      if (tx_ack) check("tx_stb_drop", 64'(tx_stb), 64'd0);
      else if (prev_stb && tx_stb) check("tx_data_stable", 64'(tx_data), 64'(prev_data));
    end
    prev_stb  = rst & tx_stb;
    prev_data = tx_data;
    if (tx_ack || !ack_en || !rst) begin
      tx_ack   = 1'b0;
      ack_wait = 0;
    end else if (tx_stb) begin
      if (ack_wait >= ack_delay) begin
        tx_ack   = 1'b1;
        ack_wait = 0;
        check("tx_has_exp", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
      end else begin
        ack_wait++;
      end
    end
  end

  // driver tasks (entered and left on a negedge)
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_load();
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
`endif
    send_byte(8'h4C);
    for (int k = 0; k < NB; k++) begin
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
      cs = cs ^ img[k];
`endif
      if (k % 4 == 3) wexp_q.push_back({AW'(k / 4), img[k], img[k-1], img[k-2], img[k-3]});
      if (k == NB - 1) begin
        exp_q.push_back(8'h06);
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
      end
      send_byte(img[k]);
      if (k % 4 == 3) check("wr_pulse", 64'({mem_en, mem_we}), 64'd3);
      else            check("wr_idle", 64'(mem_en), 64'd0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic do_dump(input int delay, input bit inject_l);
    logic [31:0] word_v;
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
`endif
    ack_delay = delay;
    for (int w = 0; w < NW; w++) begin
      word_v = mem[RB + w];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(word_v[8*b +: 8]);
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
        cs = cs ^ word_v[8*b +: 8];
`endif
      end
    end
`ifdef UART_IMAGE_BRIDGE_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    send_byte(8'h44);
    check("dump_rd_en", 64'({mem_en, mem_we}), 64'd2);
    check("dump_rd_addr", 64'(mem_addr), 64'(RB));
    check("dump_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("dump_lat_low", 64'(tx_stb), 64'd0);
      @(negedge clk);
    end
    check("dump_lat_high", 64'(tx_stb), 64'd1);
    if (inject_l) send_byte(8'h4C);
  endtask

  // directed sequence
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tx_stb", 64'(tx_stb), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_dw", 64'(mem_dw), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // unknown byte in IDLE is dropped
    send_byte(8'h7A);
    for (int i = 0; i < 3; i++) begin
      check("junk_busy", 64'(busy), 64'd0);
      check("junk_state", 64'(state_dbg), 64'd0);
      check("junk_mem_en", 64'(mem_en), 64'd0);
      check("junk_tx_stb", 64'(tx_stb), 64'd0);
      @(negedge clk);
    end

    // full load: first word 0x44332211 at address 0
    img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
    for (int k = 4; k < NB; k++) img[k] = 8'($urandom_range(0, 255));
    ack_delay = 0;
    do_load();
    wait_done(200, "load1");
    for (int w = 0; w < NW; w++)
      check("load1_mem", 64'(mem[w]), 64'({img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]}));

    // dump with ack delay 1; 'L' during the dump must be ignored
    preload(AW'(RB), 32'hDEADBEEF);
    for (int w = 1; w < NW; w++) preload(AW'(RB + w), $urandom);
    do_dump(1, 1'b1);
    wait_done(500, "dump1");
    for (int i = 0; i < 4; i++) begin
      check("dump1_idle_state", 64'(state_dbg), 64'd0);
      @(negedge clk);
    end

    // dump with a long ack delay
    for (int w = 0; w < NW; w++) preload(AW'(RB + w), $urandom);
    do_dump(50, 1'b0);
    wait_done(3000, "dump50");

    // all-0x5A image: XOR of an even count is zero
    for (int k = 0; k < NB; k++) img[k] = 8'h5A;
    ack_delay = 0;
    do_load();
    wait_done(200, "load5a");

    // reset in the middle of DUMP_TX
    ack_delay = 50;
    send_byte(8'h44);
    n = 0;
    while (!tx_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_tx_stb_seen", 64'(tx_stb), 64'd1);
    repeat (5) @(negedge clk);
    ack_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_tx_stb", 64'(tx_stb), 64'd0);
    check("midrst_tx_data", 64'(tx_data), 64'd0);
    check("midrst_mem_en", 64'(mem_en), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    ack_en = 1'b1;
    do_dump(0, 1'b0);
    wait_done(500, "dump_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
